// File: rtl/led_pattern_decoder.sv
// Receive-side LED pattern decoder: recovers slot index and dot/bar mode from a
// 10-LED stream, tracks slot continuity, locks on, and counts sequence errors.
module led_pattern_decoder #(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             en,
  input  logic [9:0]       leds,
  output logic [3:0]       index,
  output logic             mode,
  output logic             pat_ok,
  output logic             locked,
  output logic             seq_err,
  output logic             frame_done,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RUN_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);
  localparam logic [3:0] IDX_BLANK   = 4'd10;
  localparam logic [3:0] IDX_ILLEGAL = 4'd15;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t             r_state;
  logic [3:0]         r_index;
  logic               r_mode;
  logic               r_pat_ok;
  logic               r_seq_err;
  logic               r_frame_done;
  logic [ERR_W-1:0]   r_err_cnt;
  logic [RUN_W-1:0]   r_run;
  logic               r_have_prev;

  state_t             w_state_nxt;
  logic [3:0]         w_index_nxt;
  logic               w_mode_nxt;
  logic               w_pat_ok_nxt;
  logic               w_seq_err_nxt;
  logic               w_frame_done_nxt;
  logic [ERR_W-1:0]   w_err_cnt_nxt;
  logic [RUN_W-1:0]   w_run_nxt;
  logic               w_have_prev_nxt;

  logic [3:0]         w_dec_index;
  logic               w_dec_mode;
  logic               w_dec_legal;
  logic [3:0]         w_expected;
  logic               w_in_seq;

  // Pattern decode. Blank and the single-LED pattern 001 carry no mode
  // information, so they keep the previously decoded mode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    w_dec_index = IDX_ILLEGAL;
    w_dec_mode  = r_mode;
    w_dec_legal = 1'b0;
    if (leds == 10'h000) begin
      w_dec_index = IDX_BLANK;
      w_dec_legal = 1'b1;
    end else if (leds == 10'h001) begin
      w_dec_index = 4'd0;
      w_dec_legal = 1'b1;
    end else begin
      for (int k = 1; k < 10; k++) begin
        if (leds == (10'd1 << k)) begin
          w_dec_index = 4'(k);
          w_dec_mode  = 1'b0;
          w_dec_legal = 1'b1;
        end else if (leds == ((10'd1 << (k + 1)) - 10'd1)) begin
          w_dec_index = 4'(k);
          w_dec_mode  = 1'b1;
          w_dec_legal = 1'b1;
        end
      end
    end
  end

  // Stream period is 11 slots: 0..9 then blank, wrapping back to 0.
  assign w_expected = (r_index == IDX_BLANK) ? 4'd0 : (r_index + 4'd1);
  assign w_in_seq   = w_dec_legal && r_have_prev && (w_dec_index == w_expected);

  always_comb begin
    w_state_nxt      = r_state;
    w_index_nxt      = r_index;
    w_mode_nxt       = r_mode;
    w_pat_ok_nxt     = r_pat_ok;
    w_seq_err_nxt    = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_err_cnt_nxt    = r_err_cnt;
    w_run_nxt        = r_run;
    w_have_prev_nxt  = r_have_prev;

    if (en) begin
      w_index_nxt  = w_dec_index;
      w_mode_nxt   = w_dec_mode;
      w_pat_ok_nxt = w_dec_legal;

      unique case (r_state)
        HUNT: begin
          if (w_dec_legal) begin
            w_have_prev_nxt = 1'b1;
            if (w_in_seq && (r_run != RUN_LOCK)) begin
              w_run_nxt = r_run + 1'b1;
            end else if (!w_in_seq) begin
              w_run_nxt = '0;
            end
            if (w_run_nxt == RUN_LOCK) begin
              w_state_nxt = LOCKED;
            end
          end else begin
            w_have_prev_nxt = 1'b0;
            w_run_nxt       = '0;
          end
        end

        LOCKED: begin
          if (w_in_seq) begin
            w_frame_done_nxt = (w_dec_index == IDX_BLANK);
          end else begin
            // Out-of-sequence blanks land here too, so frame_done and
            // seq_err can never pulse together.
            w_seq_err_nxt   = 1'b1;
            w_state_nxt     = HUNT;
            w_run_nxt       = '0;
            w_have_prev_nxt = w_dec_legal;
            if (r_err_cnt != {ERR_W{1'b1}}) begin
              w_err_cnt_nxt = r_err_cnt + 1'b1;
            end
          end
        end

        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rs) begin
      r_state      <= HUNT;
      r_index      <= 4'd0;
      r_mode       <= 1'b0;
      r_pat_ok     <= 1'b0;
      r_seq_err    <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_cnt    <= '0;
      r_run        <= '0;
      r_have_prev  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_index      <= w_index_nxt;
      r_mode       <= w_mode_nxt;
      r_pat_ok     <= w_pat_ok_nxt;
      r_seq_err    <= w_seq_err_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_run        <= w_run_nxt;
      r_have_prev  <= w_have_prev_nxt;
    end
  end

  assign index      = r_index;
  assign mode       = r_mode;
  assign pat_ok     = r_pat_ok;
  assign locked     = (r_state == LOCKED);
  assign seq_err    = r_seq_err;
  assign frame_done = r_frame_done;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_led_pattern_decoder.sv
// Directed self-checking bench for led_pattern_decoder: a default instance plus
// a 2-bit error counter instance sharing the same stimulus.
module tb_led_pattern_decoder;

  logic       ck;
  logic       rs;
  logic       en;
  logic [9:0] leds;

  logic [3:0] index,   s_index;
  logic       mode,    s_mode;
  logic       pat_ok,  s_pat_ok;
  logic       locked,  s_locked;
  logic       seq_err, s_seq_err;
  logic       frame_done, s_frame_done;
  logic [7:0] err_cnt;
  logic [1:0] s_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  led_pattern_decoder #(.LOCK_COUNT(3), .ERR_W(8)) dut (
    .ck(ck), .rs(rs), .en(en), .leds(leds),
    .index(index), .mode(mode), .pat_ok(pat_ok), .locked(locked),
    .seq_err(seq_err), .frame_done(frame_done), .err_cnt(err_cnt)
  );

  led_pattern_decoder #(.LOCK_COUNT(3), .ERR_W(2)) dut_s (
    .ck(ck), .rs(rs), .en(en), .leds(leds),
    .index(s_index), .mode(s_mode), .pat_ok(s_pat_ok), .locked(s_locked),
    .seq_err(s_seq_err), .frame_done(s_frame_done), .err_cnt(s_err_cnt)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Observation vector: {index, mode, pat_ok, locked, seq_err, frame_done, err_cnt}
  function automatic logic [16:0] obs();
    return {index, mode, pat_ok, locked, seq_err, frame_done, err_cnt};
  endfunction

  function automatic logic [16:0] exp_v(input logic [3:0] idx, input logic m,
                                        input logic ok, input logic lk,
                                        input logic se, input logic fd,
                                        input logic [7:0] ec);
    return {idx, m, ok, lk, se, fd, ec};
  endfunction

  function automatic logic [9:0] dot_pat(input int idx);
    logic [9:0] p;
    p = '0;
    if (idx < 10) p[idx] = 1'b1;
    return p;
  endfunction

  // Drive one sample, let it clock in, and settle away from the edge.
  task automatic step(input logic e, input logic [9:0] l);
    en   = e;
    leds = l;
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    logic [16:0] e;
    rs = 1'b1;
    step(1'b1, 10'h3FF);
    rs = 1'b0;
    e = '0;
    n_tests++;
    if (obs() !== e) begin
      $display("FAIL reset: got %h expected %h", obs(), e);
      n_fail++;
    end
    n_tests++;
    if ({s_index, s_mode, s_pat_ok, s_locked, s_seq_err, s_frame_done, s_err_cnt} !== 11'd0) begin
      $display("FAIL reset_small: got idx=%0d err=%0d expected all zero", s_index, s_err_cnt);
      n_fail++;
    end
  endtask

  task automatic test_lock_wrap();
    logic [16:0] e;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, dot_pat(i % 11));
      e = exp_v(4'(i % 11), 1'b0, 1'b1, (i >= 3), 1'b0, (i == 10), 8'd0);
      n_tests++;
      if (obs() !== e) begin
        $display("FAIL lock_wrap[%0d]: got %h expected %h", i, obs(), e);
        n_fail++;
      end
    end
  endtask

  task automatic test_bar_mode();
    logic [16:0] e;
    logic [9:0]  p;
    for (int k = 1; k < 10; k++) begin
      p = '0;
      for (int b = 0; b <= k; b++) p[b] = 1'b1;
      step(1'b1, p);
      e = exp_v(4'(k), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      n_tests++;
      if (obs() !== e) begin
        $display("FAIL bar[%0d]: got %h expected %h", k, obs(), e);
        n_fail++;
      end
    end
    step(1'b1, 10'h000);
    e = exp_v(4'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
    n_tests++;
    if (obs() !== e) begin
      $display("FAIL bar_blank: got %h expected %h", obs(), e);
      n_fail++;
    end
    step(1'b1, 10'h001);
    e = exp_v(4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    n_tests++;
    if (obs() !== e) begin
      $display("FAIL bar_001_hold: got %h expected %h", obs(), e);
      n_fail++;
    end
    step(1'b1, 10'h002);
    e = exp_v(4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    n_tests++;
    if (obs() !== e) begin
      $display("FAIL bar_to_dot: got %h expected %h", obs(), e);
      n_fail++;
    end
  endtask

  task automatic test_illegal();
    logic [16:0] e;
    step(1'b1, 10'h004);
    e = exp_v(4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    n_tests++;
    if (obs() !== e) begin
      $display("FAIL illegal_pre: got %h expected %h", obs(), e);
      n_fail++;
    end
    step(1'b1, 10'h005);
    e = exp_v(4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    n_tests++;
    if (obs() !== e) begin
      $display("FAIL illegal: got %h expected %h", obs(), e);
      n_fail++;
    end
    // Seed at index 3, then three in-sequence samples relock on index 6.
    for (int i = 3; i <= 6; i++) begin
      step(1'b1, dot_pat(i));
      e = exp_v(4'(i), 1'b0, 1'b1, (i == 6), 1'b0, 1'b0, 8'd1);
      n_tests++;
      if (obs() !== e) begin
        $display("FAIL illegal_relock[%0d]: got %h expected %h", i, obs(), e);
        n_fail++;
      end
    end
  endtask

  task automatic test_skip();
    logic [16:0] e;
    int seq_idx [7] = '{7, 8, 9, 10, 0, 1, 2};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, dot_pat(seq_idx[i]));
      e = exp_v(4'(seq_idx[i]), 1'b0, 1'b1, 1'b1, 1'b0, (seq_idx[i] == 10), 8'd1);
      n_tests++;
      if (obs() !== e) begin
        $display("FAIL skip_pre[%0d]: got %h expected %h", i, obs(), e);
        n_fail++;
      end
    end
    step(1'b1, 10'h010);
    e = exp_v(4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    n_tests++;
    if (obs() !== e) begin
      $display("FAIL skip: got %h expected %h", obs(), e);
      n_fail++;
    end
    for (int i = 5; i <= 7; i++) begin
      step(1'b1, dot_pat(i));
      e = exp_v(4'(i), 1'b0, 1'b1, (i == 7), 1'b0, 1'b0, 8'd2);
      n_tests++;
      if (obs() !== e) begin
        $display("FAIL skip_relock[%0d]: got %h expected %h", i, obs(), e);
        n_fail++;
      end
    end
  endtask

  task automatic test_enable_gap();
    logic [16:0] e;
    int seq_idx [9] = '{8, 9, 10, 0, 1, 2, 3, 4, 5};
    for (int i = 0; i < 9; i++) begin
      step(1'b1, dot_pat(seq_idx[i]));
    end
    e = exp_v(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    n_tests++;
    if (obs() !== e) begin
      $display("FAIL gap_pre: got %h expected %h", obs(), e);
      n_fail++;
    end
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 10'h3FF);
      n_tests++;
      if (obs() !== e) begin
        $display("FAIL gap_hold[%0d]: got %h expected %h", c, obs(), e);
        n_fail++;
      end
    end
    step(1'b1, 10'h040);
    e = exp_v(4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    n_tests++;
    if (obs() !== e) begin
      $display("FAIL gap_resume: got %h expected %h", obs(), e);
      n_fail++;
    end
  endtask

  task automatic test_saturation_reset();
    logic [16:0] e;
    logic [1:0]  s_exp;
    int s;
    int bad;
    rs = 1'b1;
    step(1'b1, 10'h001);
    rs = 1'b0;
    s = 0;
    for (int n = 1; n <= 5; n++) begin
      for (int j = 0; j < 4; j++) step(1'b1, dot_pat((s + j) % 11));
      n_tests++;
      if (locked !== 1'b1 || s_locked !== 1'b1) begin
        $display("FAIL sat_lock[%0d]: got %b/%b expected 1/1", n, locked, s_locked);
        n_fail++;
      end
      bad = (s + 5) % 11;
      step(1'b1, dot_pat(bad));
      e = exp_v(4'(bad), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'(n));
      n_tests++;
      if (obs() !== e) begin
        $display("FAIL sat_err[%0d]: got %h expected %h", n, obs(), e);
        n_fail++;
      end
      s_exp = (n >= 3) ? 2'd3 : 2'(n);
      n_tests++;
      if (s_err_cnt !== s_exp || s_seq_err !== 1'b1) begin
        $display("FAIL sat_cnt[%0d]: got %0d expected %0d", n, s_err_cnt, s_exp);
        n_fail++;
      end
      s = bad;
    end
    // Mid-stream reset while hunting, with en high and an in-sequence sample.
    rs = 1'b1;
    step(1'b1, dot_pat((s + 1) % 11));
    rs = 1'b0;
    n_tests++;
    if (obs() !== 17'd0) begin
      $display("FAIL sat_reset: got %h expected %h", obs(), 17'd0);
      n_fail++;
    end
    n_tests++;
    if (s_err_cnt !== 2'd0 || s_locked !== 1'b0 || s_index !== 4'd0) begin
      $display("FAIL sat_reset_small: got err=%0d expected 0", s_err_cnt);
      n_fail++;
    end
  endtask

  initial begin
    rs   = 1'b0;
    en   = 1'b0;
    leds = '0;
    @(negedge ck);
    test_reset();
    test_lock_wrap();
    test_bar_mode();
    test_illegal();
    test_skip();
    test_enable_gap();
    test_saturation_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
